// File: rtl/character_cmd_gen_pkg.sv
// Shared definitions for the per-player character command generator:
// game_state encodings, default keycodes, state enum and a key-slot search.
package char_pkg;

    localparam int unsigned KEY_W     = 8;
    localparam int unsigned KEY_SLOTS = 4;
    localparam int unsigned KEYCODE_W = KEY_W * KEY_SLOTS;
    localparam int unsigned GS_W      = 8;
    localparam int unsigned HEALTH_W  = 8;
    localparam int unsigned CNT_W     = 8;

    localparam logic [GS_W-1:0] GS_START    = GS_W'(0);
    localparam logic [GS_W-1:0] GS_GAME     = GS_W'(1);
    localparam logic [GS_W-1:0] GS_GAMEOVER = GS_W'(2);

    localparam logic [KEY_W-1:0] KEY_LEFT_DEF   = 8'h04;
    localparam logic [KEY_W-1:0] KEY_RIGHT_DEF  = 8'h07;
    localparam logic [KEY_W-1:0] KEY_ATTACK_DEF = 8'h0D;
    localparam logic [KEY_W-1:0] KEY_DEFEND_DEF = 8'h0E;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIVE = 2'd1,
        S_HURT  = 2'd2,
        S_DEAD  = 2'd3
    } cmd_state_t;

    // True when any of the keycode slots holds the given code.
    function automatic logic key_pressed(input logic [KEYCODE_W-1:0] kc,
                                         input logic [KEY_W-1:0]     code);
        logic found;
        found = 1'b0;
        for (int i = 0; i < int'(KEY_SLOTS); i++) begin
            if (kc[i*int'(KEY_W) +: KEY_W] == code) begin
                found = 1'b1;
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/character_cmd_gen_if.sv
// Keyboard/hit-detection side to animation-FSM side bundle for one player.
interface character_cmd_gen_if;
    import char_pkg::*;

    logic [KEYCODE_W-1:0] keycode;
    logic [GS_W-1:0]      game_state;
    logic                 hit_in;
    logic [HEALTH_W-1:0]  hit_damage;

    logic                 attack;
    logic                 move_r;
    logic                 move_l;
    logic                 defend;
    logic                 hurt;
    logic                 die;
    logic [HEALTH_W-1:0]  health;

    modport master (
        output keycode, game_state, hit_in, hit_damage,
        input  attack, move_r, move_l, defend, hurt, die, health
    );

    modport slave (
        input  keycode, game_state, hit_in, hit_damage,
        output attack, move_r, move_l, defend, hurt, die, health
    );
endinterface

// File: rtl/character_cmd_gen_rise_detect.sv
// Registers a level and produces a registered one-clock pulse on its rise.
module rise_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rise
);
    logic r_q;
    logic r_rise;

    // Sample the level and flag a 0->1 change against the previous sample.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q    <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_q    <= i_d;
            r_rise <= i_d & ~r_q;
        end
    end

    assign o_rise = r_rise;
endmodule

// File: rtl/character_cmd_gen.sv
// Per-player command generator: keycodes -> move/attack/defend requests,
// hit events -> health, hurt and die. Key-driven requests change only on
// frame ticks; hits apply one Clk after hit_in.
// Optional feature macro: CMD_GEN_DEFEND_EN (defend key, damage quartering,
// attack blocking while defending). Without it defend is tied low.
module character_cmd_gen
    import char_pkg::*;
#(
    parameter logic [KEY_W-1:0]    KEY_LEFT        = KEY_LEFT_DEF,
    parameter logic [KEY_W-1:0]    KEY_RIGHT       = KEY_RIGHT_DEF,
    parameter logic [KEY_W-1:0]    KEY_ATTACK      = KEY_ATTACK_DEF,
    parameter logic [KEY_W-1:0]    KEY_DEFEND      = KEY_DEFEND_DEF,
    parameter logic [HEALTH_W-1:0] HEALTH_MAX      = 8'd100,
    parameter logic [CNT_W-1:0]    ATTACK_COOLDOWN = 8'd24,
    parameter logic [CNT_W-1:0]    HURT_HOLD       = 8'd6
)(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    character_cmd_gen_if.slave bus
);

    cmd_state_t          r_state;
    logic                r_attack, r_move_r, r_move_l, r_defend, r_hurt, r_die;
    logic [HEALTH_W-1:0] r_health;
    logic [CNT_W-1:0]    r_cooldown;
    logic [CNT_W-1:0]    r_hurt_cnt;
    logic                r_atk_prev;

    logic                w_frame_tick;
    logic                w_restart;
    logic                w_gs_game;
    logic                w_key_l, w_key_r, w_key_atk, w_key_def;
    logic [HEALTH_W-1:0] w_damage;
    logic [HEALTH_W:0]   w_health_diff;
    logic [HEALTH_W-1:0] w_health_new;
    logic                w_alive, w_hit, w_kill, w_wound, w_in_hurt, w_atk_fire;

    assign w_gs_game = (bus.game_state == GS_GAME);

    rise_detect u_frame_rise (
        .i_clk   (Clk),
        .i_rst_n (Reset),
        .i_d     (frame_clk),
        .o_rise  (w_frame_tick)
    );

    rise_detect u_game_rise (
        .i_clk   (Clk),
        .i_rst_n (Reset),
        .i_d     (w_gs_game),
        .o_rise  (w_restart)
    );

    assign w_key_l   = key_pressed(bus.keycode, KEY_LEFT);
    assign w_key_r   = key_pressed(bus.keycode, KEY_RIGHT);
    assign w_key_atk = key_pressed(bus.keycode, KEY_ATTACK);
`ifdef CMD_GEN_DEFEND_EN
    assign w_key_def = key_pressed(bus.keycode, KEY_DEFEND);
`else
    logic w_unused_def_key;
    assign w_unused_def_key = key_pressed(bus.keycode, KEY_DEFEND);
    assign w_key_def        = 1'b0;
`endif

    // Hit damage, quartered while the defend request is up; health saturates at 0.
    assign w_damage      = r_defend ? (bus.hit_damage >> 2) : bus.hit_damage;
    assign w_health_diff = {1'b0, r_health} - {1'b0, w_damage};
    assign w_health_new  = w_health_diff[HEALTH_W] ? '0 : w_health_diff[HEALTH_W-1:0];

    assign w_alive    = (r_state == S_ALIVE) || (r_state == S_HURT);
    assign w_hit      = bus.hit_in && w_alive && (w_damage != '0);
    assign w_kill     = w_hit && (w_health_new == '0);
    assign w_wound    = w_hit && !w_kill;
    assign w_in_hurt  = (r_state == S_HURT) || w_wound;
    assign w_atk_fire = w_key_atk && !r_atk_prev && (r_cooldown == '0)
                        && !w_key_def && !w_in_hurt;

    // Attack-key history for press detection, sampled every frame tick.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_atk_prev <= 1'b0;
        end else if (w_frame_tick) begin
            r_atk_prev <= w_key_atk;
        end
    end

    // Command state machine; hit is resolved before the coincident frame tick.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= S_IDLE;
            r_attack   <= 1'b0;
            r_move_r   <= 1'b0;
            r_move_l   <= 1'b0;
            r_defend   <= 1'b0;
            r_hurt     <= 1'b0;
            r_die      <= 1'b0;
            r_health   <= HEALTH_MAX;
            r_cooldown <= '0;
            r_hurt_cnt <= '0;
        end else if (!w_gs_game) begin
            r_state  <= S_IDLE;
            r_attack <= 1'b0;
            r_move_r <= 1'b0;
            r_move_l <= 1'b0;
            r_defend <= 1'b0;
            r_hurt   <= 1'b0;
            r_die    <= 1'b0;
        end else if (w_restart) begin
            r_state    <= S_ALIVE;
            r_attack   <= 1'b0;
            r_move_r   <= 1'b0;
            r_move_l   <= 1'b0;
            r_defend   <= 1'b0;
            r_hurt     <= 1'b0;
            r_die      <= 1'b0;
            r_health   <= HEALTH_MAX;
            r_cooldown <= '0;
            r_hurt_cnt <= '0;
        end else if (w_alive) begin
            if (w_kill) begin
                r_state  <= S_DEAD;
                r_health <= '0;
                r_attack <= 1'b0;
                r_move_r <= 1'b0;
                r_move_l <= 1'b0;
                r_defend <= 1'b0;
                r_hurt   <= 1'b0;
                r_die    <= 1'b1;
            end else begin
                if (w_wound) begin
                    r_state    <= S_HURT;
                    r_health   <= w_health_new;
                    r_hurt     <= 1'b1;
                    r_hurt_cnt <= HURT_HOLD;
                end
                if (w_frame_tick) begin
                    r_defend <= w_key_def;
                    r_attack <= w_atk_fire;
                    r_move_r <= w_key_r & ~w_key_l & ~w_key_def & ~w_in_hurt;
                    r_move_l <= w_key_l & ~w_key_r & ~w_key_def & ~w_in_hurt;
                    if (w_atk_fire) begin
                        r_cooldown <= ATTACK_COOLDOWN;
                    end else if (r_cooldown != '0) begin
                        r_cooldown <= r_cooldown - CNT_W'(1);
                    end
                    // A fresh hit this cycle owns the hurt counter.
                    if ((r_state == S_HURT) && !w_wound) begin
                        if (r_hurt_cnt <= CNT_W'(1)) begin
                            r_hurt_cnt <= '0;
                            r_hurt     <= 1'b0;
                            r_state    <= S_ALIVE;
                        end else begin
                            r_hurt_cnt <= r_hurt_cnt - CNT_W'(1);
                        end
                    end
                end
            end
        end
    end

    assign bus.attack = r_attack;
    assign bus.move_r = r_move_r;
    assign bus.move_l = r_move_l;
    assign bus.defend = r_defend;
    assign bus.hurt   = r_hurt;
    assign bus.die    = r_die;
    assign bus.health = r_health;

endmodule

// File: tb/tb_character_cmd_gen.sv
// Bench for character_cmd_gen: directed scenarios plus randomized traffic,
// all checked against a behavioural player model kept in this file.
module tb_character_cmd_gen;
    import char_pkg::*;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    logic frame_clk = 1'b0;

    character_cmd_gen_if bus();

    character_cmd_gen dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .bus       (bus.slave)
    );

    always #5 Clk = ~Clk;

`ifdef CMD_GEN_DEFEND_EN
    localparam bit DEF_EN = 1'b1;
`else
    localparam bit DEF_EN = 1'b0;
`endif

    localparam logic [31:0] K_ATK = 32'h000D_0000;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- behavioural player model ----------------
    localparam int M_IDLE = 0, M_ALIVE = 1, M_HURT = 2, M_DEAD = 3;
    int m_st = M_IDLE;
    int m_health = 100, m_cd = 0, m_hcnt = 0;
    bit m_atk, m_mr, m_ml, m_def, m_hurt, m_die, m_atk_prev;
    bit m_fc_q, m_tick, m_gs_q, m_rs;

    function automatic bit tb_has(input logic [31:0] kc, input int code);
        for (int i = 0; i < 4; i++) begin
            if (int'((kc >> (8 * i)) & 32'hFF) == code) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [13:0] m_vec();
        return {m_atk, m_mr, m_ml, m_def, m_hurt, m_die, 8'(m_health)};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {bus.attack, bus.move_r, bus.move_l, bus.defend, bus.hurt, bus.die, bus.health};
    endfunction

    task automatic model_clear_req();
        m_atk = 0; m_mr = 0; m_ml = 0; m_def = 0; m_hurt = 0; m_die = 0;
    endtask

    task automatic model_reset();
        m_st = M_IDLE; model_clear_req();
        m_health = 100; m_cd = 0; m_hcnt = 0; m_atk_prev = 0;
        m_fc_q = 0; m_tick = 0; m_gs_q = 0; m_rs = 0;
    endtask

    task automatic model_step();
        bit tick, rs, gs1, kl, kr, ka, kd, fresh, hurting, killed, wounded;
        int dmg, nh;
        tick = m_tick;
        rs   = m_rs;
        gs1  = (bus.game_state == 8'd1);
        m_tick = frame_clk && !m_fc_q; m_fc_q = frame_clk;
        m_rs   = gs1 && !m_gs_q;       m_gs_q = gs1;
        kl = tb_has(bus.keycode, 'h04);
        kr = tb_has(bus.keycode, 'h07);
        ka = tb_has(bus.keycode, 'h0D);
        kd = DEF_EN && tb_has(bus.keycode, 'h0E);
        fresh = ka && !m_atk_prev;
        if (tick) m_atk_prev = ka;
        if (!gs1) begin
            m_st = M_IDLE; model_clear_req();
        end else if (rs) begin
            m_st = M_ALIVE; model_clear_req(); m_health = 100; m_cd = 0; m_hcnt = 0;
        end else if (m_st == M_ALIVE || m_st == M_HURT) begin
            killed = 0; wounded = 0;
            dmg = m_def ? int'(bus.hit_damage) / 4 : int'(bus.hit_damage);
            if (bus.hit_in && dmg > 0) begin
                nh = m_health - dmg;
                if (nh < 0) nh = 0;
                m_health = nh;
                if (nh == 0) begin
                    m_st = M_DEAD; model_clear_req(); m_die = 1; killed = 1;
                end else begin
                    m_st = M_HURT; m_hurt = 1; m_hcnt = 6; wounded = 1;
                end
            end
            if (tick && !killed) begin
                hurting = (m_st == M_HURT);
                m_def = kd;
                if (hurting) begin
                    m_mr = 0; m_ml = 0; m_atk = 0;
                end else begin
                    m_mr  = kr && !kl && !kd;
                    m_ml  = kl && !kr && !kd;
                    m_atk = fresh && (m_cd == 0) && !kd;
                end
                if (m_atk) m_cd = 24;
                else if (m_cd > 0) m_cd = m_cd - 1;
                if (hurting && !wounded) begin
                    m_hcnt = m_hcnt - 1;
                    if (m_hcnt <= 0) begin
                        m_hcnt = 0; m_hurt = 0; m_st = M_ALIVE;
                    end
                end
            end
        end
    endtask

    // Model advances on the same edges the design sees.
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) model_reset();
        else        model_step();
    end

    // ---------------- stimulus helpers ----------------
    task automatic frame(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk); frame_clk = 1'b1;
            @(negedge Clk);
            @(negedge Clk); frame_clk = 1'b0;
            @(negedge Clk);
            @(negedge Clk);
        end
    endtask

    task automatic hit(input int dmg);
        @(negedge Clk); bus.hit_in = 1'b1; bus.hit_damage = 8'(dmg);
        @(negedge Clk); bus.hit_in = 1'b0; bus.hit_damage = 8'd0;
    endtask

    function automatic logic [31:0] rand_kc();
        logic [31:0] kc;
        kc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 7))
                0: kc[i*8 +: 8] = 8'h04;
                1: kc[i*8 +: 8] = 8'h07;
                2: kc[i*8 +: 8] = 8'h0D;
                3: kc[i*8 +: 8] = 8'h0E;
                4: kc[i*8 +: 8] = 8'($urandom);
                default: kc[i*8 +: 8] = 8'h00;
            endcase
        end
        return kc;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(negedge Clk);
        n_checks++;
        if (dut_vec() !== {6'b0, 8'd100}) begin
            n_fail++; $display("FAIL reset_state got=%h exp=%h", dut_vec(), {6'b0, 8'd100});
        end
        @(negedge Clk); Reset = 1'b1;
        repeat (2) @(negedge Clk);
        n_checks++;
        if (dut_vec() !== {6'b0, 8'd100}) begin
            n_fail++; $display("FAIL restart_state got=%h exp=%h", dut_vec(), {6'b0, 8'd100});
        end
        bus.keycode = 32'h0000_0007;
        frame(1);
        n_checks++;
        if (bus.move_r !== 1'b1) begin
            n_fail++; $display("FAIL first_move_r got=%b exp=1", bus.move_r);
        end
        n_checks++;
        if (dut_vec() !== m_vec()) begin
            n_fail++; $display("FAIL reset_model got=%h exp=%h", dut_vec(), m_vec());
        end
    endtask

    task automatic test_left_right();
        bus.keycode = 32'h0004_0007;
        frame(1);
        n_checks++;
        if ({bus.move_l, bus.move_r} !== 2'b00) begin
            n_fail++; $display("FAIL left_right_both got=%b%b exp=00", bus.move_l, bus.move_r);
        end
        bus.keycode = 32'h0400_0000;
        frame(1);
        n_checks++;
        if ({bus.move_l, bus.move_r} !== 2'b10) begin
            n_fail++; $display("FAIL left_slot3 got=%b%b exp=10", bus.move_l, bus.move_r);
        end
    endtask

    task automatic test_attack();
        int cnt;
        bus.keycode = 32'h0;
        frame(1);
        bus.keycode = K_ATK;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            frame(1);
            if (bus.attack === 1'b1) cnt++;
        end
        n_checks++;
        if (cnt != 1) begin
            n_fail++; $display("FAIL attack_hold got=%0d pulses exp=1", cnt);
        end
        bus.keycode = 32'h0; frame(1);
        bus.keycode = K_ATK; frame(1);
        n_checks++;
        if (bus.attack !== 1'b1) begin
            n_fail++; $display("FAIL attack_t0 got=%b exp=1", bus.attack);
        end
        bus.keycode = 32'h0; frame(9);
        bus.keycode = K_ATK; frame(1);
        n_checks++;
        if (bus.attack !== 1'b0) begin
            n_fail++; $display("FAIL attack_cooldown_t10 got=%b exp=0", bus.attack);
        end
        bus.keycode = 32'h0; frame(19);
        bus.keycode = K_ATK; frame(1);
        n_checks++;
        if (bus.attack !== 1'b1) begin
            n_fail++; $display("FAIL attack_t30 got=%b exp=1", bus.attack);
        end
        frame(1);
        n_checks++;
        if (bus.attack !== 1'b0) begin
            n_fail++; $display("FAIL attack_one_frame got=%b exp=0", bus.attack);
        end
        bus.keycode = 32'h0; frame(1);
    endtask

    task automatic test_hit();
        int exp_h;
        hit(30);
        n_checks++;
        if ({bus.hurt, bus.health} !== {1'b1, 8'd70}) begin
            n_fail++; $display("FAIL hit30 got hurt=%b health=%0d exp hurt=1 health=70", bus.hurt, bus.health);
        end
        for (int i = 1; i <= 6; i++) begin
            frame(1);
            n_checks++;
            if (bus.hurt !== 1'(i < 6)) begin
                n_fail++; $display("FAIL hurt_hold tick=%0d got=%b exp=%b", i, bus.hurt, i < 6);
            end
        end
        bus.keycode = 32'h0000_0E00;
        frame(1);
        n_checks++;
        if (bus.defend !== DEF_EN) begin
            n_fail++; $display("FAIL defend_level got=%b exp=%b", bus.defend, DEF_EN);
        end
        hit(30);
        exp_h = DEF_EN ? 63 : 40;
        n_checks++;
        if (int'(bus.health) != exp_h) begin
            n_fail++; $display("FAIL defend_damage got=%0d exp=%0d", bus.health, exp_h);
        end
        bus.keycode = 32'h0;
        frame(7);
        n_checks++;
        if (dut_vec() !== m_vec()) begin
            n_fail++; $display("FAIL hit_model got=%h exp=%h", dut_vec(), m_vec());
        end
    endtask

    task automatic test_die();
        int cur;
        cur = DEF_EN ? 63 : 40;
        hit(cur - 20);
        frame(7);
        n_checks++;
        if (bus.health !== 8'd20) begin
            n_fail++; $display("FAIL health_20 got=%0d exp=20", bus.health);
        end
        bus.keycode = 32'h0000_0007;
        frame(1);
        hit(50);
        n_checks++;
        if (dut_vec() !== {5'b00000, 1'b1, 8'd0}) begin
            n_fail++; $display("FAIL die_state got=%h exp=%h", dut_vec(), {6'b000001, 8'd0});
        end
        bus.keycode = K_ATK | 32'h0000_0004;
        frame(3);
        hit(10);
        frame(1);
        n_checks++;
        if (dut_vec() !== {6'b000001, 8'd0}) begin
            n_fail++; $display("FAIL dead_ignores got=%h exp=%h", dut_vec(), {6'b000001, 8'd0});
        end
        bus.keycode = 32'h0;
        bus.game_state = 8'd0;
        repeat (2) @(negedge Clk);
        n_checks++;
        if ({bus.die, bus.health} !== {1'b0, 8'd0}) begin
            n_fail++; $display("FAIL idle_after_gs0 got die=%b health=%0d exp die=0 health=0", bus.die, bus.health);
        end
        bus.game_state = 8'd1;
        repeat (2) @(negedge Clk);
        n_checks++;
        if (dut_vec() !== {6'b0, 8'd100}) begin
            n_fail++; $display("FAIL restart_health got=%h exp=%h", dut_vec(), {6'b0, 8'd100});
        end
    endtask

    task automatic test_coincident();
        bus.keycode = 32'h0;
        frame(1);
        @(negedge Clk); bus.keycode = K_ATK; frame_clk = 1'b1;
        @(negedge Clk); bus.hit_in = 1'b1; bus.hit_damage = 8'd10;
        @(negedge Clk); bus.hit_in = 1'b0; bus.hit_damage = 8'd0;
        n_checks++;
        if ({bus.attack, bus.hurt, bus.health} !== {1'b0, 1'b1, 8'd90}) begin
            n_fail++; $display("FAIL coincident got atk=%b hurt=%b health=%0d exp atk=0 hurt=1 health=90",
                               bus.attack, bus.hurt, bus.health);
        end
        n_checks++;
        if (dut_vec() !== m_vec()) begin
            n_fail++; $display("FAIL coincident_model got=%h exp=%h", dut_vec(), m_vec());
        end
        frame_clk = 1'b0;
        bus.keycode = 32'h0;
        frame(7);
    endtask

    task automatic test_async_reset();
        bus.keycode = K_ATK;
        frame(1);
        hit(15);
        @(negedge Clk);
        #2 Reset = 1'b0;
        #1;
        n_checks++;
        if (dut_vec() !== {6'b0, 8'd100}) begin
            n_fail++; $display("FAIL async_reset got=%h exp=%h", dut_vec(), {6'b0, 8'd100});
        end
        n_checks++;
        if (dut_vec() !== m_vec()) begin
            n_fail++; $display("FAIL async_reset_model got=%h exp=%h", dut_vec(), m_vec());
        end
        bus.keycode = 32'h0;
        @(negedge Clk); Reset = 1'b1;
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_random();
        int shown;
        int dead_cycles;
        shown = 0;
        dead_cycles = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge Clk);
            n_checks++;
            if (dut_vec() !== m_vec()) begin
                n_fail++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), m_vec());
                end
            end
            if ($urandom_range(0, 7) == 0) bus.keycode = rand_kc();
            if ((cyc % 4) == 0 || $urandom_range(0, 9) == 0) frame_clk = ~frame_clk;
            bus.hit_in     = ($urandom_range(0, 19) == 0);
            bus.hit_damage = 8'($urandom_range(0, 45));
            dead_cycles = m_die ? dead_cycles + 1 : 0;
            if (bus.game_state != 8'd1) begin
                if ($urandom_range(0, 5) == 0) bus.game_state = 8'd1;
            end else if (dead_cycles > 40 || $urandom_range(0, 499) == 0) begin
                bus.game_state = 8'($urandom_range(0, 1) * 2);
            end
        end
        bus.hit_in = 1'b0;
        bus.game_state = 8'd1;
    endtask

    initial begin
        bus.keycode    = 32'h0;
        bus.game_state = 8'd1;
        bus.hit_in     = 1'b0;
        bus.hit_damage = 8'd0;
        model_reset();
        test_reset();
        test_left_right();
        test_attack();
        test_hit();
        test_die();
        test_coincident();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/character_cmd_gen.md
# character_cmd_gen

Per-player command generator that drives the action-request inputs of a character animation FSM. Decodes the four-slot USB keyboard keycode word into move, attack and defend requests, and tracks the character's health from incoming hit events to produce hurt and die requests. Requests update on `frame_clk` ticks so the animation FSM sees stable levels across a frame. One instance exists per player, between the keyboard/hit-detection logic and that player's animation FSM.

## Interface
- `KEY_LEFT`, default 8'h04, keycode for move-left.
- `KEY_RIGHT`, default 8'h07, keycode for move-right.
- `KEY_ATTACK`, default 8'h0D, keycode for attack.
- `KEY_DEFEND`, default 8'h0E, keycode for defend.
- `HEALTH_MAX`, default 8'd100, health loaded on reset and restart.
- `ATTACK_COOLDOWN`, default 8'd24, frame ticks before another attack is accepted.
- `HURT_HOLD`, default 8'd6, frame ticks `hurt` stays high after a hit.
- `Clk` input 1: system clock.
- `Reset` input 1: asynchronous, active-low reset.
- `frame_clk` input 1: VGA frame clock, asynchronous level.
- `keycode` input 32: four 8-bit key slots; 8'h00 means empty.
- `game_state` input 8: 0 start, 1 game, 2 gameover.
- `hit_in` input 1: one-Clk pulse, opponent attack landed.
- `hit_damage` input 8: damage, valid with `hit_in`.
- `attack` output 1, `move_r` output 1, `move_l` output 1, `defend` output 1, `hurt` output 1, `die` output 1: action requests.
- `health` output 8: current health.

## Operation
- States: S_IDLE, S_ALIVE, S_HURT, S_DEAD.
- Reset: S_IDLE, every output 0, `health`=HEALTH_MAX, cooldown 0, hurt counter 0.
- Restart: a rising edge of (`game_state`==1) loads S_ALIVE, `health`=HEALTH_MAX, clears every request and counter. `game_state`≠1 forces S_IDLE and clears requests; `health` holds its value.
- Key decode: a key is pressed if any of the four slots equals its code. Left and right together decode as neither.
- On each frame tick in S_ALIVE or S_HURT:
  - `move_r`/`move_l` follow the decoded keys.
  - `defend` follows the defend key. When `defend` is 1, `move_*` are 0.
  - `attack` goes high for exactly one frame period when the attack key is newly pressed (up at the previous tick), cooldown is 0, and `defend` is 0. Cooldown then loads ATTACK_COOLDOWN.
  - Cooldown decrements by 1 per tick and saturates at 0.
- Hit handling (S_ALIVE/S_HURT only; ignored in S_IDLE/S_DEAD):
  - damage = `defend` ? `hit_damage`>>2 : `hit_damage`.
  - `health` = max(0, health−damage), computed 9-bit then saturated.
  - Damage 0 has no effect.
  - Result 0: S_DEAD, `die`=1, and all other requests are cleared.
  - Result >0: S_HURT, `hurt`=1, hurt counter=HURT_HOLD. A hit during S_HURT reloads the counter.
- S_HURT: counter decrements per tick. At 0, `hurt`=0 and the state returns to S_ALIVE. Moves and attack stay 0 while in S_HURT; cooldown still decrements.
- S_DEAD: `die` stays high until restart or reset; keys are ignored.

## Timing
- Frame tick: `frame_clk` registered, and the rise is detected into a registered one-Clk `frame_tick`. Key-driven outputs update on the Clk edge where `frame_tick`=1.
- Hit: `health`, `hurt` and `die` update 1 Clk after `hit_in`, independent of `frame_tick`.
- `hit_in` coincident with `frame_tick`: the hit is applied first. A hit that kills clears requests in that same cycle.
- Restart detection: `game_state` compare is registered, then edge-detected. Restart takes effect 2 Clk after `game_state` becomes 1 and overrides a coincident hit or tick.
- `Reset` low at any time clears immediately (asynchronous), mid-hurt or mid-cooldown included.

## Configuration
- `CMD_GEN_DEFEND_EN` defined:
  - defend key decoded and `defend` driven as above;
  - damage quartered while defending;
  - attack blocked while defending.
- `CMD_GEN_DEFEND_EN` undefined:
  - `defend` tied 0;
  - full damage always;
  - defend keycode ignored.

## Structure
- Shared package `char_pkg`:
  - game_state encoding constants GS_START=0, GS_GAME=1, GS_GAMEOVER=2;
  - default keycode constants;
  - cmd state enum typedef.
- Sub-module `rise_detect`: register plus rising-edge pulse. Instantiated twice, for `frame_clk` and for (`game_state`==1).

## Test plan
- Reset low, then high with `game_state`=1 → 2 Clk later `health`=100 and all requests 0; after a tick with keycode=32'h00000007, `move_r`=1.
- keycode=32'h0004_0007 → at the next tick `move_l`=`move_r`=0.
- Attack key held across 30 ticks → `attack` high for exactly 1 tick period; press, release, press again at tick 10 → no attack; press again after tick 24 → attack.
- `hit_in` with damage 30 → 1 Clk later `health`=70 and `hurt`=1; `hurt` falls after 6 ticks. With defend held, damage 30 → `health`−7.
- `health`=20, hit with damage 50 → `health`=0, `die`=1, other requests 0; further keys and hits have no effect until `game_state` goes 0→1, which restores `health`=100.
- `hit_in` and `frame_tick` in the same cycle with the attack key newly pressed → hurt taken, `attack`=0.
